knn_ctrl: RTL and testbench

Sequencer for the KNN squared-distance core. On a start pulse it walks a training-point memory and streams each point, paired with a stored test point, into the distance core. It samples each distance and keeps a sorted list of the K nearest points. Optionally it computes a majority label. It sits between the CPU-visible register file and `knn_core`.

---
 rtl/knn_pkg.sv | 24 ++
 rtl/knn_sort_list.sv | 72 +++++++
 rtl/knn_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_knn_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/knn_pkg.sv
// knn_pkg: FSM encoding, training-word layout and feed order shared by knn_ctrl.
package knn_pkg;
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_LOAD    = 4'd2;
    localparam logic [3:0] S_FEED0   = 4'd4;
    localparam logic [3:0] S_FEED1   = 4'd5;
    localparam logic [3:0] S_FEED2   = 4'd6;
    localparam logic [3:0] S_FEED3   = 4'd7;
    localparam logic [3:0] S_WAIT    = 4'd8;
    localparam logic [3:0] S_SAMPLE  = 4'd9;
    localparam logic [3:0] S_CAPTURE = 4'd10;
    localparam logic [3:0] S_VOTE    = 4'd11;
    localparam logic [3:0] S_DONE    = 4'd12;
    // mem_rdata = {label, x, y}; field offsets counted in DATA_W units
    localparam int OFS_Y  = 0;
    localparam int OFS_X  = 1;
    localparam int OFS_LB = 2;
    // FEED0..3 sit at 4..7 so the low two state bits pick the operand
    localparam logic [1:0] FD_TX = 2'd0;
    localparam logic [1:0] FD_X  = 2'd1;
    localparam logic [1:0] FD_TY = 2'd2;
    localparam logic [1:0] FD_Y  = 2'd3;
endpackage

// File: rtl/knn_sort_list.sv
// knn_sort_list: K-entry list kept ascending by distance; inserts shift worse entries down.
module knn_sort_list #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int LABEL_W = 4,
    parameter int K       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 ins,
    input  logic [ADDR_W-1:0]    idx_i,
    input  logic [DATA_W-1:0]    dist_i,
    input  logic [LABEL_W-1:0]   label_i,
    output logic [K-1:0]         valid_o,
    output logic [K*ADDR_W-1:0]  idx_o,
    output logic [K*DATA_W-1:0]  dist_o,
    output logic [K*LABEL_W-1:0] label_o
);
    logic [K-1:0]         v_q, v_d, lt, lt_p, v_sh;
    logic [K*ADDR_W-1:0]  i_q, i_d, i_sh;
    logic [K*DATA_W-1:0]  d_q, d_d, d_sh;
    logic [K*LABEL_W-1:0] l_q, l_d, l_sh;
    // a slot accepts the new point if empty or strictly worse, so ties keep the older entry ahead
    always_comb begin
        lt = '0;
        for (int j = 0; j < K; j++) lt[j] = !v_q[j] || dist_i < d_q[j*DATA_W +: DATA_W];
    end
    assign lt_p = K'({lt, 1'b0});
    assign v_sh = K'({v_q, 1'b0});
    assign i_sh = (K*ADDR_W)'({i_q, {ADDR_W{1'b0}}});
    assign d_sh = (K*DATA_W)'({d_q, {DATA_W{1'b0}}});
    assign l_sh = (K*LABEL_W)'({l_q, {LABEL_W{1'b0}}});
    always_comb begin
        v_d = v_q;
        i_d = i_q;
        d_d = d_q;
        l_d = l_q;
        if (clr) begin
            v_d = '0;
            i_d = '0;
            d_d = '0;
            l_d = '0;
        end else if (ins) begin
            for (int j = 0; j < K; j++) begin
                if (lt[j]) begin
                    v_d[j] = lt_p[j] ? v_sh[j] : 1'b1;
                    i_d[j*ADDR_W +: ADDR_W] = lt_p[j] ? i_sh[j*ADDR_W +: ADDR_W] : idx_i;
                    d_d[j*DATA_W +: DATA_W] = lt_p[j] ? d_sh[j*DATA_W +: DATA_W] : dist_i;
                    l_d[j*LABEL_W +: LABEL_W] = lt_p[j] ? l_sh[j*LABEL_W +: LABEL_W] : label_i;
                end
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            i_q <= '0;
            d_q <= '0;
            l_q <= '0;
        end else begin
            v_q <= v_d;
            i_q <= i_d;
            d_q <= d_d;
            l_q <= l_d;
        end
    end
    assign valid_o = v_q;
    assign idx_o   = i_q;
    assign dist_o  = d_q;
    assign label_o = l_q;
endmodule

// File: rtl/knn_ctrl.sv
// knn_ctrl: streams training points through knn_core and keeps the K nearest.
// Define KNN_VOTE_EN to add a K-cycle majority-label vote after the last point.
module knn_ctrl
    import knn_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int LABEL_W = 4,
    parameter int K       = 4,
    parameter int DP_LAT  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           n_points,
    input  logic [DATA_W-1:0]           test_x,
    input  logic [DATA_W-1:0]           test_y,
    output logic                        mem_rd,
    output logic [ADDR_W-1:0]           mem_addr,
    input  logic [LABEL_W+2*DATA_W-1:0] mem_rdata,
    output logic                        dp_enable,
    output logic [DATA_W-1:0]           dp_data_in,
    output logic                        dp_sample,
    input  logic [DATA_W-1:0]           dp_value,
    output logic                        busy,
    output logic                        done,
    output logic [K-1:0]                nn_valid,
    output logic [K*ADDR_W-1:0]         nn_idx,
    output logic [K*DATA_W-1:0]         nn_dist,
    output logic [LABEL_W-1:0]          nn_label
);
    localparam int WW = $clog2(DP_LAT + 2);
    logic [3:0]           st_q, st_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]    tx_q, tx_d, ty_q, ty_d, px_q, px_d, py_q, py_d;
    logic [LABEL_W-1:0]   pl_q, pl_d;
    logic [WW-1:0]        wt_q, wt_d;
    logic                 clr, feed, vote_last;
    logic [1:0]           sel;
    logic [K-1:0]         lst_v;
    logic [K*LABEL_W-1:0] lst_l;
`ifdef KNN_VOTE_EN
    localparam logic [3:0] S_LAST = S_VOTE;
    localparam int VW = $clog2(K + 1);
    logic [VW-1:0]      vi_q, vi_d, bc_q, bc_d, cnt_v;
    logic [LABEL_W-1:0] bl_q, bl_d, lab_q, lab_d, cur;
    logic               cv;
    // cycle vi_q: count valid entries sharing entry vi_q's label; only a strictly larger count wins
    always_comb begin
        cur = '0;
        cv = 1'b0;
        for (int j = 0; j < K; j++) begin
            if (VW'(j) == vi_q) begin
                cur = lst_l[j*LABEL_W +: LABEL_W];
                cv = lst_v[j];
            end
        end
        cnt_v = '0;
        for (int j = 0; j < K; j++) cnt_v = cnt_v + VW'(lst_v[j] && lst_l[j*LABEL_W +: LABEL_W] == cur);
        vi_d = vi_q;
        bc_d = bc_q;
        bl_d = bl_q;
        lab_d = st_q == S_DONE ? bl_q : lab_q;
        if (clr) begin
            vi_d = '0;
            bc_d = '0;
            bl_d = '0;
        end else if (st_q == S_VOTE) begin
            vi_d = vi_q + 1'b1;
            if (cv && cnt_v > bc_q) begin
                bc_d = cnt_v;
                bl_d = cur;
            end
        end
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vi_q <= '0;
            bc_q <= '0;
            bl_q <= '0;
            lab_q <= '0;
        end else begin
            vi_q <= vi_d;
            bc_q <= bc_d;
            bl_q <= bl_d;
            lab_q <= lab_d;
        end
    end
    assign vote_last = vi_q == VW'(K - 1);
    assign nn_label = lab_q;
`else
    localparam logic [3:0] S_LAST = S_DONE;
    logic [LABEL_W-1:0] lab_c;
    // nearest valid entry; valid entries are contiguous from slot 0, so this is slot 0 or nothing
    always_comb begin
        lab_c = '0;
        for (int j = K - 1; j >= 0; j--) if (lst_v[j]) lab_c = lst_l[j*LABEL_W +: LABEL_W];
    end
    assign vote_last = 1'b1;
    assign nn_label = lab_c;
`endif
    assign clr = st_q == S_IDLE && start;
    always_comb begin
        st_d = st_q;
        cnt_d = cnt_q;
        tx_d = tx_q;
        ty_d = ty_q;
        px_d = px_q;
        py_d = py_q;
        pl_d = pl_q;
        wt_d = '0;
        case (st_q)
            S_IDLE: if (start) begin
                tx_d = test_x;
                ty_d = test_y;
                cnt_d = '0;
                st_d = n_points == '0 ? S_DONE : S_FETCH;
            end
            S_FETCH: st_d = S_LOAD;
            S_LOAD: begin
                pl_d = mem_rdata[OFS_LB*DATA_W +: LABEL_W];
                px_d = mem_rdata[OFS_X*DATA_W +: DATA_W];
                py_d = mem_rdata[OFS_Y*DATA_W +: DATA_W];
                st_d = S_FEED0;
            end
            S_FEED0, S_FEED1, S_FEED2: st_d = st_q + 4'd1;
            S_FEED3: st_d = DP_LAT == 0 ? S_SAMPLE : S_WAIT;
            S_WAIT: begin
                st_d = wt_q == WW'(DP_LAT - 1) ? S_SAMPLE : S_WAIT;
                wt_d = wt_q == WW'(DP_LAT - 1) ? '0 : wt_q + 1'b1;
            end
            S_SAMPLE: st_d = S_CAPTURE;
            S_CAPTURE: begin
                st_d = cnt_q == n_points - ADDR_W'(1) ? S_LAST : S_FETCH;
                cnt_d = cnt_q == n_points - ADDR_W'(1) ? cnt_q : cnt_q + 1'b1;
            end
            S_VOTE: st_d = vote_last ? S_DONE : S_VOTE;
            default: st_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q <= S_IDLE;
            cnt_q <= '0;
            tx_q <= '0;
            ty_q <= '0;
            px_q <= '0;
            py_q <= '0;
            pl_q <= '0;
            wt_q <= '0;
        end else begin
            st_q <= st_d;
            cnt_q <= cnt_d;
            tx_q <= tx_d;
            ty_q <= ty_d;
            px_q <= px_d;
            py_q <= py_d;
            pl_q <= pl_d;
            wt_q <= wt_d;
        end
    end
    assign feed = st_q[3:2] == 2'b01;
    assign sel = st_q[1:0];
    assign mem_rd = st_q == S_FETCH;
    assign mem_addr = mem_rd ? cnt_q : '0;
    assign dp_enable = st_q >= S_FEED0 && st_q <= S_CAPTURE;
    assign dp_data_in = !feed ? '0 : sel == FD_TX ? tx_q : sel == FD_X ? px_q : sel == FD_TY ? ty_q : py_q;
    assign dp_sample = st_q == S_SAMPLE;
    assign busy = st_q != S_IDLE;
    assign done = st_q == S_DONE;
    knn_sort_list #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LABEL_W(LABEL_W), .K(K)) u_list (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .ins(st_q == S_CAPTURE),
        .idx_i(cnt_q),
        .dist_i(dp_value),
        .label_i(pl_q),
        .valid_o(lst_v),
        .idx_o(nn_idx),
        .dist_o(nn_dist),
        .label_o(lst_l)
    );
    assign nn_valid = lst_v;
endmodule

// File: tb/tb_knn_ctrl.sv
// tb_knn_ctrl: directed bench for knn_ctrl with a memory model and a squared-distance core model.
module tb_knn_ctrl;
    import knn_pkg::*;
    localparam int DW = 16, AW = 8, LW = 4, K = 4, DL = 2;
`ifdef KNN_VOTE_EN
    localparam int VL = K;
    localparam bit VOTE = 1'b1;
`else
    localparam int VL = 0;
    localparam bit VOTE = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [AW-1:0] n_points = '0;
    logic [DW-1:0] test_x = '0, test_y = '0;
    logic mem_rd, dp_enable, dp_sample, busy, done;
    logic [AW-1:0] mem_addr;
    logic [LW+2*DW-1:0] mem_rdata = '0;
    logic [DW-1:0] dp_data_in, dp_value = '0;
    logic [K-1:0] nn_valid;
    logic [K*AW-1:0] nn_idx;
    logic [K*DW-1:0] nn_dist;
    logic [LW-1:0] nn_label;
    int checks = 0, errors = 0;

    knn_ctrl #(.DATA_W(DW), .ADDR_W(AW), .LABEL_W(LW), .K(K), .DP_LAT(DL)) dut (
        .clk(clk), .rst(rst), .start(start), .n_points(n_points), .test_x(test_x), .test_y(test_y),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dp_enable(dp_enable),
        .dp_data_in(dp_data_in), .dp_sample(dp_sample), .dp_value(dp_value), .busy(busy), .done(done),
        .nn_valid(nn_valid), .nn_idx(nn_idx), .nn_dist(nn_dist), .nn_label(nn_label)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mx [256], my [256];
    logic [LW-1:0] ml [256];
    always @(posedge clk) if (mem_rd) mem_rdata <= {ml[mem_addr], mx[mem_addr], my[mem_addr]};

    function automatic int sq(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int d;
        d = int'(a) - int'(b);
        return d * d;
    endfunction

    // core model: first four enabled words are the operands, result one cycle after dp_sample
    logic [DW-1:0] w [4];
    int wc = 0;
    always @(posedge clk) begin
        if (!dp_enable) wc <= 0;
        else if (wc < 4) begin
            w[wc[1:0]] <= dp_data_in;
            wc <= wc + 1;
        end
        if (dp_sample) dp_value <= DW'(sq(w[0], w[1]) + sq(w[2], w[3]));
    end

    logic [DW-1:0] cur_tx = '0, cur_ty = '0;
    logic [AW-1:0] alog [1024];
    logic [AW-1:0] last_a = '0;
    int rd_tot = 0, smp_tot = 0, feed_bad = 0;
    always @(negedge clk) begin
        if (mem_rd) begin
            alog[10'(rd_tot)] <= mem_addr;
            last_a <= mem_addr;
            rd_tot <= rd_tot + 1;
        end
        if (dp_sample) begin
            smp_tot <= smp_tot + 1;
            if (w[0] !== cur_tx || w[1] !== mx[last_a] || w[2] !== cur_ty || w[3] !== my[last_a])
                feed_bad <= feed_bad + 1;
        end
    end

    task automatic set_pt(input int i, input int x, input int y, input int l);
        mx[i[7:0]] = DW'(x);
        my[i[7:0]] = DW'(y);
        ml[i[7:0]] = LW'(l);
    endtask

    task automatic go(input int n, input int x, input int y, input int poke, output int lat, output int bb);
        n_points = AW'(n);
        test_x = DW'(x);
        test_y = DW'(y);
        cur_tx = DW'(x);
        cur_ty = DW'(y);
        start = 1'b1;
        lat = 0;
        bb = 0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 2000; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            if (!busy) bb++;
            start = k == poke;
            if (k == poke) begin
                test_x = ~DW'(x);
                test_y = ~DW'(y);
            end
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if ({mem_rd, dp_enable, dp_sample, busy, done} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b want 00000", {mem_rd, dp_enable, dp_sample, busy, done}); end
        checks++; if (mem_addr !== '0 || dp_data_in !== '0) begin errors++; $display("FAIL reset_bus: addr %0h data %0h want 0", mem_addr, dp_data_in); end
        checks++; if (nn_valid !== '0 || nn_idx !== '0 || nn_dist !== '0 || nn_label !== '0) begin errors++; $display("FAIL reset_list: valid %b idx %0h dist %0h label %0h want 0", nn_valid, nn_idx, nn_dist, nn_label); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat, bb, r0, s0, f0;
        set_pt(0, 3, 1, 5);
        r0 = rd_tot; s0 = smp_tot; f0 = feed_bad;
        go(1, 4, 2, 0, lat, bb);
        checks++; if (lat !== 11 + VL) begin errors++; $display("FAIL single_latency: got %0d want %0d", lat, 11 + VL); end
        checks++; if (bb !== 0 || busy !== 1'b0) begin errors++; $display("FAIL single_busy: gaps %0d busy_after %b want 0 0", bb, busy); end
        checks++; if (nn_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b want 0001", nn_valid); end
        checks++; if (nn_idx !== 32'h0) begin errors++; $display("FAIL single_idx: got %0h want 0", nn_idx); end
        checks++; if (nn_dist !== 64'd2) begin errors++; $display("FAIL single_dist: got %0h want 2", nn_dist); end
        checks++; if (nn_label !== 4'd5) begin errors++; $display("FAIL single_label: got %0d want 5", nn_label); end
        checks++; if (rd_tot - r0 !== 1 || smp_tot - s0 !== 1 || feed_bad - f0 !== 0) begin errors++; $display("FAIL single_protocol: reads %0d samples %0d feed_bad %0d want 1 1 0", rd_tot - r0, smp_tot - s0, feed_bad - f0); end
    endtask

    task automatic test_sort(input int a3, input int a5, input int a1, input int a2, input int ev);
        int lat, bb, r0, s0, f0, el;
        el = VOTE ? ev : a3;
        set_pt(0, 3, 9, 9); set_pt(1, 13, 10, a1); set_pt(2, 10, 7, a2);
        set_pt(3, 11, 10, a3); set_pt(4, 10, 0, 9); set_pt(5, 10, 12, a5);
        r0 = rd_tot; s0 = smp_tot; f0 = feed_bad;
        go(6, 10, 10, 0, lat, bb);
        checks++; if (lat !== 61 + VL) begin errors++; $display("FAIL sort_latency: got %0d want %0d", lat, 61 + VL); end
        checks++; if (nn_valid !== 4'b1111) begin errors++; $display("FAIL sort_valid: got %b want 1111", nn_valid); end
        checks++; if (nn_idx !== {8'd2, 8'd1, 8'd5, 8'd3}) begin errors++; $display("FAIL sort_idx: got %h want 02010503", nn_idx); end
        checks++; if (nn_dist !== {16'd9, 16'd9, 16'd4, 16'd1}) begin errors++; $display("FAIL sort_dist: got %h want 0009000900040001", nn_dist); end
        checks++; if (nn_label !== LW'(el)) begin errors++; $display("FAIL sort_label: got %0d want %0d", nn_label, el); end
        checks++; if (rd_tot - r0 !== 6 || smp_tot - s0 !== 6 || feed_bad - f0 !== 0) begin errors++; $display("FAIL sort_protocol: reads %0d samples %0d feed_bad %0d want 6 6 0", rd_tot - r0, smp_tot - s0, feed_bad - f0); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (alog[10'(r0 + i)] !== AW'(i)) begin errors++; $display("FAIL sort_addr%0d: got %0d want %0d", i, alog[10'(r0 + i)], i); end
        end
    endtask

    task automatic test_empty();
        int lat, bb, r0;
        r0 = rd_tot;
        go(0, 1, 1, 0, lat, bb);
        checks++; if (lat !== 1) begin errors++; $display("FAIL empty_latency: got %0d want 1", lat); end
        checks++; if (rd_tot - r0 !== 0) begin errors++; $display("FAIL empty_reads: got %0d want 0", rd_tot - r0); end
        checks++; if (nn_valid !== '0 || nn_dist !== '0 || nn_idx !== '0) begin errors++; $display("FAIL empty_list: valid %b dist %0h idx %0h want 0", nn_valid, nn_dist, nn_idx); end
        checks++; if (nn_label !== '0) begin errors++; $display("FAIL empty_label: got %0d want 0", nn_label); end
    endtask

    task automatic test_busy_start();
        int lat, bb, r0, s0, f0;
        set_pt(0, 3, 9, 6); set_pt(1, 13, 10, 3);
        r0 = rd_tot; s0 = smp_tot; f0 = feed_bad;
        go(2, 10, 10, 15, lat, bb);
        checks++; if (lat !== 21 + VL || bb !== 0) begin errors++; $display("FAIL busy_latency: got %0d gaps %0d want %0d 0", lat, bb, 21 + VL); end
        checks++; if (nn_valid !== 4'b0011) begin errors++; $display("FAIL busy_valid: got %b want 0011", nn_valid); end
        checks++; if (nn_idx !== {16'h0, 8'd0, 8'd1}) begin errors++; $display("FAIL busy_idx: got %h want 00000001", nn_idx); end
        checks++; if (nn_dist !== {32'h0, 16'd50, 16'd9}) begin errors++; $display("FAIL busy_dist: got %h want 0000000000320009", nn_dist); end
        checks++; if (nn_label !== 4'd3) begin errors++; $display("FAIL busy_label: got %0d want 3", nn_label); end
        checks++; if (rd_tot - r0 !== 2 || smp_tot - s0 !== 2 || feed_bad - f0 !== 0) begin errors++; $display("FAIL busy_protocol: reads %0d samples %0d feed_bad %0d want 2 2 0", rd_tot - r0, smp_tot - s0, feed_bad - f0); end
    endtask

    task automatic test_reset_mid();
        set_pt(0, 3, 9, 9); set_pt(1, 13, 10, 2); set_pt(2, 10, 7, 4);
        n_points = 8'd6; test_x = 16'd10; test_y = 16'd10; cur_tx = 16'd10; cur_ty = 16'd10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (26) @(negedge clk);
        checks++; if ({dp_enable, dp_sample, mem_rd, busy} !== 4'b1001) begin errors++; $display("FAIL mid_wait: got %b want 1001", {dp_enable, dp_sample, mem_rd, busy}); end
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_rd, dp_enable, dp_sample, busy, done, mem_addr, dp_data_in, nn_valid, nn_idx, nn_dist, nn_label} !== '0) begin errors++; $display("FAIL mid_outputs: valid %b idx %0h dist %0h busy %b want 0", nn_valid, nn_idx, nn_dist, busy); end
        checks++; if (dut.st_q !== S_IDLE) begin errors++; $display("FAIL mid_state: got %0d want %0d", dut.st_q, S_IDLE); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        test_sort(1, 2, 3, 4, 1);
    endtask

    initial begin
        test_reset();
        test_single();
        test_sort(2, 7, 7, 2, 2);
        test_sort(3, 7, 7, 1, 7);
        test_sort(1, 2, 3, 4, 1);
        test_empty();
        test_busy_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
